uart_tx_arbiter: RTL

- Shares one uart_tx serializer among NUM_CH byte requesters using round-robin arbitration.
- Accepts one byte per grant through a valid/ready handshake. Drives the serializer's tx_start and data_in, then waits for its tx_done before issuing the next grant.
- Sits between the per-channel TX FIFOs and the single uart_tx instance.
- A watchdog recovers the arbiter if tx_done never arrives.

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_CH byte requesters, with a tx_done watchdog.
// Optional inter-frame idle gap enabled by defining UART_ARB_GAP_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*8-1:0]       req_data,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      timeout_err
);

    // state | meaning
    // IDLE  | waiting for any req_valid; grants on the edge it sees one
    // WAIT  | frame handed to uart_tx; waiting for tx_done or watchdog expiry
    // GAP   | idle spacing between frames (UART_ARB_GAP_EN builds only)

    localparam int IDW = $clog2(NUM_CH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 2 || GAP_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
`ifdef UART_ARB_GAP_EN
        ,GAP = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [WDW-1:0]   wd_cnt;
    logic             sel_found;
    logic [IDW-1:0]   sel;
    int               idx;

`ifdef UART_ARB_GAP_EN
    localparam int GPW = $clog2(GAP_CYCLES + 1);
    logic [GPW-1:0]   gap_cnt;
`endif

    // First set req_valid bit scanning upward from the channel after the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!sel_found && req_valid[idx[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel       = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
            last        <= IDW'(NUM_CH - 1);
`ifdef UART_ARB_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        tx_data        <= req_data[{sel, 3'b000} +: 8];
                        tx_start       <= 1'b1;
                        req_ready[sel] <= 1'b1;
                        grant_id       <= sel;
                        last           <= sel;
                        wd_cnt         <= '0;
                        busy           <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // tx_done takes priority over a watchdog expiry in the same cycle
                    if (tx_done) begin
`ifdef UART_ARB_GAP_EN
                        gap_cnt <= '0;
                        state   <= GAP;
`else
                        busy    <= 1'b0;
                        state   <= IDLE;
`endif
                    end else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
`ifdef UART_ARB_GAP_EN
                GAP: begin
                    if (gap_cnt == GPW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
